// File: rtl/mips_pkg.sv
// Shared types and geometry helpers for the instruction cache.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FILL
    } icache_state_t;

    function automatic int unsigned off_w(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned lines,
                                          input int unsigned words_per_line);
        return addr_w - 2 - $clog2(lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/inst_cache_refill.sv
// Refill controller: miss FSM, word counter and the req/ready word handshake
// toward instruction memory. Drives write and validate strobes into the arrays.
module inst_cache_refill
    import mips_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned OFF_W          = off_w(WORDS_PER_LINE),
    parameter int unsigned LINE_W         = ADDR_W - 2 - OFF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss,
    input  logic [LINE_W-1:0] miss_line,
    input  logic              mem_ready,
    output logic              idle,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              wr_en,
    output logic [OFF_W-1:0]  wr_word,
    output logic              fill_en,
    output logic [LINE_W-1:0] line_q
);

    icache_state_t     state_q, state_d;
    logic [OFF_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LINE_W-1:0] line_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_q     <= line_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_d     = line_q;
        idle       = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        wr_en      = 1'b0;
        fill_en    = 1'b0;
        wr_word    = word_cnt_q;
        case (state_q)
            IDLE: begin
                idle = 1'b1;
                if (miss) begin
                    state_d    = REFILL;
                    line_d     = miss_line;
                    word_cnt_d = '0;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {line_q, word_cnt_q, 2'b00};
                if (mem_ready) begin
                    wr_en = 1'b1;
                    // Incrementing past the last word wraps the counter to 0
                    // on the same edge that enters FILL.
                    word_cnt_d = word_cnt_q + OFF_W'(1);
                    if (word_cnt_q == OFF_W'(WORDS_PER_LINE - 1))
                        state_d = FILL;
                end
            end
            FILL: begin
                fill_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with combinational lookup.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
module inst_cache
    import mips_pkg::*;
#(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               hit,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ready
`ifdef ICACHE_STATS_EN
   ,output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int unsigned OFF_W  = off_w(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = idx_w(LINES);
    localparam int unsigned TAG_W  = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
    localparam int unsigned LINE_W = TAG_W + IDX_W;

    logic [INSTR_W-1:0] data_q [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q, valid_d;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic              pc_byte_unused;

    logic              idle, miss, wr_en, fill_en;
    logic [OFF_W-1:0]  wr_word;
    logic [LINE_W-1:0] line_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;

    assign pc_off         = pc[OFF_W+1:2];
    assign pc_idx         = pc[OFF_W+2 +: IDX_W];
    assign pc_tag         = pc[ADDR_W-1 -: TAG_W];
    assign pc_byte_unused = ^pc[1:0];

    assign wr_idx = line_q[IDX_W-1:0];
    assign wr_tag = line_q[LINE_W-1 -: TAG_W];

    always_comb begin
        hit         = idle && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
        miss        = idle && !hit;
        instruction = hit ? data_q[pc_idx][pc_off] : '0;
    end

    inst_cache_refill #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ADDR_W         (ADDR_W)
    ) u_refill (
        .clk       (clk),
        .reset     (reset),
        .miss      (miss),
        .miss_line ({pc_tag, pc_idx}),
        .mem_ready (mem_ready),
        .idle      (idle),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .wr_en     (wr_en),
        .wr_word   (wr_word),
        .fill_en   (fill_en),
        .line_q    (line_q)
    );

    always_ff @(posedge clk) begin
        if (wr_en)
            data_q[wr_idx][wr_word] <= mem_rdata;
        if (fill_en)
            tag_q[wr_idx] <= wr_tag;
    end

    always_comb begin
        valid_d = valid_q;
        if (fill_en)
            valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && hit_count_q != '1)
            hit_count_d = hit_count_q + 32'd1;
        if (miss && miss_count_q != '1)
            miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache; memory returns 32'hA0 + address.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int wr_total = 0;
    int wr_base;
    int steps;

    always #5 clk = ~clk;

    assign mem_rdata = 32'hA0 + mem_addr;

    always @(posedge clk)
        if (mem_req && mem_ready)
            wr_total <= wr_total + 1;

    inst_cache #(
        .LINES          (16),
        .WORDS_PER_LINE (4),
        .ADDR_W         (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
`ifdef ICACHE_STATS_EN
       ,.hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit(input string tag, input int exp_steps);
        int n = 0;
        while (hit !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, n, exp_steps);
    endtask

    initial begin
        reset     = 1'b1;
        pc        = 32'h0;
        mem_ready = 1'b1;
        step();
        step();
        chk("rst_hit", {31'b0, hit}, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);

        // 1: cold miss at pc=0, six stall cycles
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t1_stall", {31'b0, hit}, 32'h0);
            if (i == 1) chk("t1_addr0", mem_addr, 32'h0);
            if (i == 4) chk("t1_addr3", mem_addr, 32'hC);
            step();
        end
        chk("t1_hit", {31'b0, hit}, 32'h1);
        chk("t1_instr", instruction, 32'hA0);

        // 2: rest of line 0 hits
        for (int p = 4; p <= 12; p += 4) begin
            pc = p;
            #1;
            chk("t2_hit", {31'b0, hit}, 32'h1);
            chk("t2_instr", instruction, 32'hA0 + p);
            chk("t2_req", {31'b0, mem_req}, 32'h0);
            step();
        end

        // 3: pc=64 (index 4), then 256 evicts line 0, then 0 misses again
        pc = 32'd64;
        #1;
        chk("t3_miss64", {31'b0, hit}, 32'h0);
        step();
        chk("t3_addr64", mem_addr, 32'd64);
        wait_hit("t3_lat64", 5);
        chk("t3_instr64", instruction, 32'hE0);
        pc = 32'd256;
        #1;
        chk("t3_miss256", {31'b0, hit}, 32'h0);
        wait_hit("t3_lat256", 6);
        chk("t3_instr256", instruction, 32'h1A0);
        pc = 32'd0;
        #1;
        chk("t3_evicted", {31'b0, hit}, 32'h0);
        wait_hit("t3_lat0", 6);
        chk("t3_instr0", instruction, 32'hA0);
        pc = 32'd68;
        #1;
        chk("t3_keep64", instruction, 32'hE4);

        // 4: mem_ready alternating during refill of pc=128
        pc        = 32'd128;
        mem_ready = 1'b1;
        wr_base   = wr_total;
        #1;
        chk("t4_miss", {31'b0, hit}, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            mem_ready = (k % 2 == 0);
            chk("t4_req", {31'b0, mem_req}, 32'h1);
            chk("t4_addr", mem_addr, 32'd128 + 32'd4 * ((k - 1) / 2));
        end
        step();
        mem_ready = 1'b1;
        chk("t4_fill", {31'b0, hit}, 32'h0);
        step();
        chk("t4_hit", {31'b0, hit}, 32'h1);
        chk("t4_writes", wr_total - wr_base, 32'd4);
        pc = 32'd140;
        #1;
        chk("t4_instr", instruction, 32'h12C);

        // 5: reset on the second refill beat of pc=192
        pc = 32'd192;
        step();
        step();
        chk("t5_beat2", mem_addr, 32'd196);
        reset = 1'b1;
        step();
        chk("t5_req", {31'b0, mem_req}, 32'h0);
        reset = 1'b0;
        #1;
        chk("t5_miss192", {31'b0, hit}, 32'h0);
        pc = 32'd0;
        #1;
        chk("t5_miss0", {31'b0, hit}, 32'h0);
        wait_hit("t5_lat0", 6);
        chk("t5_instr0", instruction, 32'hA0);

        // 6: pc moves to 256 mid-refill of line 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        pc    = 32'd0;
        #1;
        chk("t6_miss0", {31'b0, hit}, 32'h0);
        step();
        chk("t6_addr0", mem_addr, 32'd0);
        step();
        pc = 32'd256;
        #1;
        chk("t6_addr1", mem_addr, 32'd4);
        chk("t6_stall", {31'b0, hit}, 32'h0);
        step();
        step();
        chk("t6_addr3", mem_addr, 32'd12);
        step();
        chk("t6_fill", {31'b0, hit}, 32'h0);
        step();
        chk("t6_idle_miss", {31'b0, hit}, 32'h0);
        chk("t6_idle_req", {31'b0, mem_req}, 32'h0);
        pc = 32'd0;
        #1;
        chk("t6_line0", instruction, 32'hA0);
        pc = 32'd256;
        #1;
        wait_hit("t6_lat256", 6);
        chk("t6_instr256", instruction, 32'h1A0);
`ifdef ICACHE_STATS_EN
        chk("t6_miss_count", miss_count, 32'd2);
        chk("t6_hit_count0", hit_count, 32'd0);
        step();
        chk("t6_hit_count1", hit_count, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
